// File: rtl/mc_datapath_if.sv
// Control-unit <-> datapath bundle: register/bus controls, ALU launch, and status back.
interface mc_datapath_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int SEL_W      = $clog2(NUM_REGS)
);
  logic [2:0]            bus_src;
  logic [SEL_W-1:0]      rd_sel;
  logic [SEL_W-1:0]      wr_sel;
  logic                  gpr_we;
  logic                  ba_mode;
  logic                  y_we;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] ext_in;
  logic [3:0]            op;
  logic                  op_start;
  logic [DATA_WIDTH-1:0] bus_out;
  logic                  busy;
  logic                  done;
  logic                  zero_flag;

  modport master (
    output bus_src, rd_sel, wr_sel, gpr_we, ba_mode, y_we, hi_we, lo_we,
           imm, ext_in, op, op_start,
    input  bus_out, busy, done, zero_flag
  );

  modport slave (
    input  bus_src, rd_sel, wr_sel, gpr_we, ba_mode, y_we, hi_we, lo_we,
           imm, ext_in, op, op_start,
    output bus_out, busy, done, zero_flag
  );
endinterface

// File: rtl/mc_datapath.sv
// Single-bus CPU datapath: GPR file, HI/LO, Y, 2W-bit Z, and an ALU with
// single-cycle ops plus iterative signed MUL (shift-add) / DIV (restoring).
module mc_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic           clock,
  input  logic           clear,
  mc_datapath_if.slave   dp
);
  localparam int W     = DATA_WIDTH;
  localparam int SH_W  = $clog2(DATA_WIDTH);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4,  OP_SHL = 4'd5,  OP_ROR = 4'd6,  OP_ROL = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8,  OP_NOT = 4'd9,  OP_MUL = 4'd10, OP_DIV = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  logic [W-1:0]     gpr_q [NUM_REGS];
  logic [W-1:0]     hi_q, lo_q, y_q;
  logic [2*W-1:0]   z_q, z_d;
  logic             z_we;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             load;

  // Operands latched at launch; acc_hi/acc_lo double as product or remainder/quotient.
  logic             is_div_q, neg_q, rneg_q, bzero_q;
  logic [W-1:0]     a_q, d_q;
  logic [W:0]       acc_hi_q, hi_n;
  logic [W-1:0]     acc_lo_q, lo_n;

  logic [W-1:0]     bus, a, b, alu_res, a_abs, b_abs;
  logic [SH_W-1:0]  sh;

  always_comb begin
    bus = '0;
    case (dp.bus_src)
      3'd0:    bus = (dp.ba_mode && dp.rd_sel == '0) ? '0 : gpr_q[dp.rd_sel];
      3'd1:    bus = hi_q;
      3'd2:    bus = lo_q;
      3'd3:    bus = z_q[W-1:0];
      3'd4:    bus = z_q[2*W-1:W];
      3'd5:    bus = dp.imm;
      3'd6:    bus = dp.ext_in;
      default: bus = '0;
    endcase
  end

  assign dp.bus_out   = bus;
  assign dp.busy      = (state_q == S_RUN);
  assign dp.done      = done_q;
  assign dp.zero_flag = (z_q[W-1:0] == '0);

  assign a     = y_q;
  assign b     = bus;
  assign sh    = b[SH_W-1:0];
  assign a_abs = a[W-1] ? -a : a;
  assign b_abs = b[W-1] ? -b : b;

  always_comb begin
    alu_res = b;
    case (dp.op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SHR:  alu_res = a >> sh;
      OP_SHL:  alu_res = a << sh;
      OP_ROR:  alu_res = (a >> sh) | (a << (W - int'(sh)));
      OP_ROL:  alu_res = (a << sh) | (a >> (W - int'(sh)));
      OP_NEG:  alu_res = -b;
      OP_NOT:  alu_res = ~b;
      OP_INC:  alu_res = b + 1'b1;
      default: alu_res = b;
    endcase
  end

  // One MUL or DIV iteration on the accumulator pair.
  logic [W:0] mul_sum, div_sh, div_diff;
  always_comb begin
    mul_sum  = acc_hi_q + {1'b0, d_q};
    div_sh   = {acc_hi_q[W-1:0], acc_lo_q[W-1]};
    div_diff = div_sh - {1'b0, d_q};
    hi_n     = acc_hi_q;
    lo_n     = acc_lo_q;
    if (is_div_q) begin
      if (!div_diff[W]) begin
        hi_n = div_diff;
        lo_n = {acc_lo_q[W-2:0], 1'b1};
      end else begin
        hi_n = div_sh;
        lo_n = {acc_lo_q[W-2:0], 1'b0};
      end
    end else if (acc_lo_q[0]) begin
      {hi_n, lo_n} = {1'b0, mul_sum, acc_lo_q[W-1:1]};
    end else begin
      {hi_n, lo_n} = {1'b0, acc_hi_q, acc_lo_q[W-1:1]};
    end
  end

  logic [2*W-1:0] prod, final_z;
  logic [W-1:0]   quo, rem;
  always_comb begin
    prod = {hi_n[W-1:0], lo_n};
    quo  = neg_q  ? -lo_n : lo_n;
    rem  = rneg_q ? -hi_n[W-1:0] : hi_n[W-1:0];
    if (!is_div_q)    final_z = neg_q ? -prod : prod;
    else if (bzero_q) final_z = {a_q, {W{1'b1}}};
    else              final_z = {rem, quo};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    z_we    = 1'b0;
    z_d     = z_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dp.op_start) begin
          if (dp.op == OP_MUL || dp.op == OP_DIV) begin
            load    = 1'b1;
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            z_we   = 1'b1;
            z_d    = {{W{1'b0}}, alu_res};
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = S_IDLE;
          z_we    = 1'b1;
          z_d     = final_z;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      y_q      <= '0;
      z_q      <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else begin
      if (dp.gpr_we) gpr_q[dp.wr_sel] <= bus;
      if (dp.hi_we)  hi_q <= bus;
      if (dp.lo_we)  lo_q <= bus;
      if (dp.y_we)   y_q  <= bus;
      if (z_we)      z_q  <= z_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (load) begin
        is_div_q <= (dp.op == OP_DIV);
        neg_q    <= a[W-1] ^ b[W-1];
        rneg_q   <= a[W-1];
        bzero_q  <= (b == '0);
        a_q      <= a;
        d_q      <= b_abs;
        acc_hi_q <= '0;
        acc_lo_q <= a_abs;
      end else if (state_q == S_RUN) begin
        acc_hi_q <= hi_n;
        acc_lo_q <= lo_n;
      end
    end
  end
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: reset, ALU ops, MUL/DIV timing, base-address mode.
module tb_mc_datapath;
  logic clock = 1'b0;
  logic clear;
  int   n_chk = 0;
  int   n_err = 0;

  mc_datapath_if #(.DATA_WIDTH(32), .NUM_REGS(16)) dp ();
  mc_datapath #(.DATA_WIDTH(32), .NUM_REGS(16)) dut (.clock(clock), .clear(clear), .dp(dp));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dp.bus_src = 3'd7; dp.rd_sel = '0; dp.wr_sel = '0;
    dp.gpr_we = 0; dp.ba_mode = 0; dp.y_we = 0; dp.hi_we = 0; dp.lo_we = 0;
    dp.imm = '0; dp.ext_in = '0; dp.op = '0; dp.op_start = 0;
  endtask

  // dst: 0 GPR[sel], 1 HI, 2 LO, 3 Y
  task automatic put(input int dst, input logic [3:0] sel, input logic [31:0] val);
    dp.bus_src = 3'd5; dp.imm = val; dp.wr_sel = sel;
    dp.gpr_we = (dst == 0); dp.hi_we = (dst == 1); dp.lo_we = (dst == 2); dp.y_we = (dst == 3);
    tick();
    idle();
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] bval);
    dp.bus_src = 3'd5; dp.imm = bval; dp.op = op; dp.op_start = 1;
    tick();
    idle();
  endtask

  task automatic rd(input logic [2:0] src, input logic [3:0] sel, output logic [31:0] val);
    dp.bus_src = src; dp.rd_sel = sel;
    #1;
    val = dp.bus_out;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    put(0, 4'd3, 32'h1234); put(1, 0, 32'h11); put(2, 0, 32'h22); put(3, 0, 32'h5);
    launch(4'd0, 32'h1);
    rd(3'd3, 0, v);
    n_chk++; if (v !== 32'h6) begin n_err++; $display("FAIL pre_reset_z: got %h exp %h", v, 32'h6); end
    clear = 0; dp.imm = 32'hBEEF; dp.ext_in = 32'hCAFE;
    tick();
    rd(3'd6, 0, v);
    n_chk++; if (v !== 32'hCAFE) begin n_err++; $display("FAIL reset_ext_in: got %h exp %h", v, 32'hCAFE); end
    rd(3'd5, 0, v);
    n_chk++; if (v !== 32'hBEEF) begin n_err++; $display("FAIL reset_imm: got %h exp %h", v, 32'hBEEF); end
    rd(3'd7, 0, v);
    n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL bus_zero_src: got %h exp 0", v); end
    clear = 1; idle();
    rd(3'd0, 4'd3, v);
    n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_r3: got %h exp 0", v); end
    rd(3'd1, 0, v);
    n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h exp 0", v); end
    rd(3'd2, 0, v);
    n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h exp 0", v); end
    rd(3'd3, 0, v);
    n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_zlo: got %h exp 0", v); end
    rd(3'd4, 0, v);
    n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_zhi: got %h exp 0", v); end
    n_chk++; if ({dp.zero_flag, dp.busy, dp.done} !== 3'b100)
      begin n_err++; $display("FAIL reset_flags: got zf/busy/done=%b exp 100", {dp.zero_flag, dp.busy, dp.done}); end
    // Y cleared: ADD Y + 0 must give 0, after first making Z nonzero
    launch(4'd13, 32'h9);
    dp.bus_src = 3'd7; dp.op = 4'd0; dp.op_start = 1;
    tick(); idle();
    rd(3'd3, 0, v);
    n_chk++; if (v !== 32'h0 || dp.zero_flag !== 1'b1)
      begin n_err++; $display("FAIL reset_y: got zlo %h zf %b exp 0 1", v, dp.zero_flag); end
  endtask

  task automatic test_add();
    logic [31:0] v;
    put(3, 0, 32'h7FFF_FFFF);
    launch(4'd0, 32'h1);
    n_chk++; if (dp.done !== 1'b1 || dp.busy !== 1'b0)
      begin n_err++; $display("FAIL add_done: got done/busy=%b%b exp 10", dp.done, dp.busy); end
    rd(3'd3, 0, v);
    n_chk++; if (v !== 32'h8000_0000) begin n_err++; $display("FAIL add_zlo: got %h exp 80000000", v); end
    rd(3'd4, 0, v);
    n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL add_zhi: got %h exp 0", v); end
    tick();
    n_chk++; if (dp.done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse: got %b exp 0", dp.done); end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [11] = '{4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd12, 4'd13};
    logic [31:0] av  [11] = '{32'h1, 32'h5, 32'hF0F0_FF00, 32'hF0F0_FF00, 32'h8000_0000, 32'h1,
                              32'h8000_0001, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] bv  [11] = '{32'd33, 32'h7, 32'h0FF0_F0F0, 32'h0FF0_F0F0, 32'd36, 32'd31,
                              32'd1, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1234};
    logic [31:0] ev  [11] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'h00F0_F000, 32'hFFF0_FFF0, 32'h0800_0000,
                              32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1234};
    logic [31:0] v;
    for (int i = 0; i < 11; i++) begin
      put(3, 0, av[i]);
      launch(ops[i], bv[i]);
      rd(3'd3, 0, v);
      n_chk++; if (v !== ev[i] || dp.zero_flag !== (ev[i] == 0))
        begin n_err++; $display("FAIL alu_op%0d: got %h zf %b exp %h", ops[i], v, dp.zero_flag, ev[i]); end
    end
  endtask

  task automatic test_mul();
    logic [31:0] v, hi;
    logic ok = 1;
    launch(4'd13, 32'hAAAA);
    put(3, 0, 32'hFFFF_FFFD);
    launch(4'd10, 32'd7);                         // edge k
    for (int i = 1; i < 32; i++) begin
      if (i == 2) begin dp.bus_src = 3'd5; dp.imm = 32'h0; dp.y_we = 1; end
      if (i == 5) begin dp.bus_src = 3'd5; dp.imm = 32'h3; dp.op = 4'd0; dp.op_start = 1; end
      tick(); idle();
      if (dp.busy !== 1'b1 || dp.done !== 1'b0) ok = 0;
      if (i == 10) begin
        rd(3'd3, 0, v);
        n_chk++; if (v !== 32'hAAAA) begin n_err++; $display("FAIL mul_z_hold: got %h exp 0000aaaa", v); end
      end
    end
    n_chk++; if (!ok) begin n_err++; $display("FAIL mul_busy_window: got early end exp busy 31 cycles"); end
    tick();                                       // edge k+32
    n_chk++; if (dp.busy !== 1'b0 || dp.done !== 1'b1)
      begin n_err++; $display("FAIL mul_finish: got busy/done=%b%b exp 01", dp.busy, dp.done); end
    rd(3'd3, 0, v); rd(3'd4, 0, hi);
    n_chk++; if ({hi, v} !== 64'hFFFF_FFFF_FFFF_FFEB)
      begin n_err++; $display("FAIL mul_result: got %h exp ffffffffffffffeb", {hi, v}); end
    tick();
    n_chk++; if (dp.done !== 1'b0 || dp.busy !== 1'b0)
      begin n_err++; $display("FAIL mul_after: got busy/done=%b%b exp 00", dp.busy, dp.done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, hi;
    put(3, 0, 32'hFFFF_FFF9);
    launch(4'd11, 32'd2);
    for (int i = 1; i < 32; i++) tick();
    put(3, 0, 32'd7);                             // Y write in the final RUN cycle is harmless
    n_chk++; if (dp.done !== 1'b1) begin n_err++; $display("FAIL div_done: got %b exp 1", dp.done); end
    rd(3'd3, 0, v); rd(3'd4, 0, hi);
    n_chk++; if ({hi, v} !== 64'hFFFF_FFFF_FFFF_FFFD)
      begin n_err++; $display("FAIL div_neg7_2: got %h exp ffffffff_fffffffd", {hi, v}); end
    launch(4'd11, 32'd0);                         // accepted in the done cycle
    n_chk++; if (dp.busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy %b exp 1", dp.busy); end
    for (int i = 1; i < 32; i++) tick();
    n_chk++; if (dp.busy !== 1'b1 || dp.done !== 1'b0)
      begin n_err++; $display("FAIL div0_latency: got busy/done=%b%b exp 10", dp.busy, dp.done); end
    tick();
    rd(3'd3, 0, v); rd(3'd4, 0, hi);
    n_chk++; if ({hi, v} !== 64'h0000_0007_FFFF_FFFF || dp.done !== 1'b1)
      begin n_err++; $display("FAIL div_by_zero: got %h done %b exp 00000007ffffffff 1", {hi, v}, dp.done); end
  endtask

  task automatic test_ba_mode();
    logic [31:0] v;
    put(0, 4'd0, 32'h55);
    dp.ba_mode = 1;
    rd(3'd0, 4'd0, v);
    n_chk++; if (v !== 32'h0) begin n_err++; $display("FAIL ba_mask: got %h exp 0", v); end
    dp.ba_mode = 0;
    rd(3'd0, 4'd0, v);
    n_chk++; if (v !== 32'h55) begin n_err++; $display("FAIL ba_off: got %h exp 55", v); end
    dp.ba_mode = 1; dp.bus_src = 3'd5; dp.imm = 32'h66; dp.gpr_we = 1; dp.wr_sel = 4'd0;
    tick(); idle();
    rd(3'd0, 4'd0, v);
    n_chk++; if (v !== 32'h66) begin n_err++; $display("FAIL ba_write_r0: got %h exp 66", v); end
    put(0, 4'd5, 32'h11);
    dp.gpr_we = 1; dp.wr_sel = 4'd5;
    rd(3'd0, 4'd5, v);
    n_chk++; if (v !== 32'h11) begin n_err++; $display("FAIL rw_old: got %h exp 11", v); end
    dp.bus_src = 3'd5; dp.imm = 32'h22;
    tick(); idle();
    rd(3'd0, 4'd5, v);
    n_chk++; if (v !== 32'h22) begin n_err++; $display("FAIL rw_new: got %h exp 22", v); end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] v, hi;
    logic ok = 1;
    launch(4'd13, 32'h77);
    put(3, 0, 32'd5);
    launch(4'd10, 32'd6);                         // edge k
    for (int i = 1; i < 10; i++) tick();
    clear = 0;
    tick();                                       // edge k+10
    clear = 1;
    rd(3'd3, 0, v); rd(3'd4, 0, hi);
    n_chk++; if ({hi, v} !== 64'h0 || dp.busy !== 1'b0 || dp.done !== 1'b0)
      begin n_err++; $display("FAIL midrun_reset: got z %h busy %b done %b exp 0 0 0", {hi, v}, dp.busy, dp.done); end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dp.done !== 1'b0 || dp.busy !== 1'b0) ok = 0;
    end
    n_chk++; if (!ok) begin n_err++; $display("FAIL midrun_no_done: got activity exp none"); end
    put(3, 0, 32'd100);
    launch(4'd11, 32'hFFFF_FFF9);
    for (int i = 1; i < 32; i++) tick();
    tick();
    rd(3'd3, 0, v); rd(3'd4, 0, hi);
    n_chk++; if ({hi, v} !== 64'h0000_0002_FFFF_FFF2 || dp.done !== 1'b1)
      begin n_err++; $display("FAIL div_after_reset: got %h done %b exp 00000002fffffff2 1", {hi, v}, dp.done); end
  endtask

  initial begin
    idle();
    clear = 0;
    tick(); tick();
    clear = 1;
    tick();
    test_reset();
    test_add();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_ba_mode();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mc_datapath.md
# mc_datapath

Parametrised bus-based CPU datapath: a `NUM_REGS`-entry general register file, HI/LO, Y and a 2×`DATA_WIDTH` Z register around a single shared bus, driven by external control signals from the control unit. It has a multi-cycle ALU: single-cycle logic/arith/shift ops, plus iterative signed multiply and divide with a start/busy/done handshake. It also has a base-address mode that forces R0 to read as zero. It replaces fixed-width datapath instances and sits between the control-unit FSM and memory/I/O.

## Interface
- `DATA_WIDTH`, 32, width of bus and all registers; must be ≥ 4 and a power of 2
- `NUM_REGS`, 16, general register count; power of 2, ≥ 2
- `SEL_W`, clog2(`NUM_REGS`), register-select width; derived, do not override
- `clock`  input  1  single clock; all state updates on rising edge
- `clear`  input  1  synchronous, active-low reset
- `bus_src`  input  3  bus source: 0 GPR[`rd_sel`], 1 HI, 2 LO, 3 Zlo, 4 Zhi, 5 `imm`, 6 `ext_in`, 7 zero
- `rd_sel`  input  `SEL_W`  GPR read index
- `wr_sel`  input  `SEL_W`  GPR write index
- `gpr_we`  input  1  GPR[`wr_sel`] ← bus
- `ba_mode`  input  1  while high, GPR[0] reads as 0 on the bus
- `y_we`, `hi_we`, `lo_we`  input  1 each  load Y / HI / LO from bus
- `imm`  input  `DATA_WIDTH`  sign-extended constant from IR
- `ext_in`  input  `DATA_WIDTH`  in-port data
- `op`  input  4  ALU opcode
- `op_start`  input  1  launch ALU op (A = Y, B = bus)
- `bus_out`  output  `DATA_WIDTH`  current bus value (combinational)
- `busy`  output  1  multi-cycle op in progress
- `done`  output  1  one-cycle pulse: Z written by previous edge
- `zero_flag`  output  1  Zlo == 0 (combinational from Z)

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 SHR logical, 5 SHL, 6 ROR, 7 ROL, 8 NEG(B), 9 NOT(B), 10 MUL, 11 DIV, 12 INC(B+1), 13–15 pass B.
- Shift and rotate amount is B[clog2(`DATA_WIDTH`)−1:0]; upper bits of B are ignored.
- Single-cycle ops write Zlo = result and Zhi = 0. Arithmetic is modulo 2^`DATA_WIDTH`.
- MUL: signed A×B, full 2×`DATA_WIDTH` product in {Zhi, Zlo}. Shift-add or Booth, one step per cycle.
- DIV: signed restoring. Zlo = quotient truncated toward zero; Zhi = remainder, with the sign of the dividend (A).
- DIV by 0: Zlo = all ones, Zhi = A. Completes with normal latency and never hangs.
- FSM states:
  - IDLE: `op_start` with a single-cycle op → Z written, stay in IDLE. `op_start` with MUL/DIV → latch operands, go to RUN, count = 0.
  - RUN: one iteration per cycle. After `DATA_WIDTH` iterations, write Z and return to IDLE.
- `op_start` while in RUN is ignored: no effect, no queuing.
- Operands are latched at launch. Writes to Y, GPR, HI or LO during RUN do not affect the result. Z is not modified until completion.
- Bus sources other than Z stay fully usable during RUN.
- Same-cycle read and write of one GPR: the bus shows the old value; the new value is visible the next cycle.
- `ba_mode` only masks reads of R0. Writes to R0 proceed normally.
- `bus_src` = 7 drives all zeros.

## Timing
- Reset (`clear` = 0 at an edge) clears all GPRs, HI, LO, Y and Z to 0, FSM → IDLE, `busy` = 0, `done` = 0. This is fine mid-RUN: no Z write occurs.
- Reset outputs: `bus_out` = 0 for any `bus_src` (all sources zero, except `imm` and `ext_in`, which pass through); `zero_flag` = 1.
- Register writes take effect at the edge where the enable is sampled.
- Single-cycle op, `op_start` at edge k: Z valid after edge k, `done` high for the cycle after edge k, `busy` stays 0.
- MUL/DIV, `op_start` at edge k:
  - `busy` rises after edge k.
  - Iterations run on edges k+1 … k+`DATA_WIDTH`.
  - Z is written at edge k+`DATA_WIDTH`; `busy` falls at that same edge.
  - `done` is high for one cycle after it.
- Back-to-back: a new `op_start` is accepted in the cycle `done` is high.

## Test plan
- Reset: preload R3 = 0x1234, assert `clear` low for one edge → R3, HI, LO, Y and Z read 0; `zero_flag` = 1; `busy` = `done` = 0.
- ADD: Y = 0x7FFFFFFF, bus = `imm` 1, ADD → Zlo = 0x80000000, Zhi = 0, `done` pulses 1 cycle after launch. ROR: Y = 0x00000001, B = 33 → Zlo = 0x80000000.
- MUL: Y = −3, B = 7 → {Zhi, Zlo} = 0xFFFFFFFF_FFFFFFEB. Z written at edge k+32; `busy` high 32 cycles; `op_start` at k+5 ignored.
- DIV: −7 / 2 → Zlo = −3, Zhi = −1. 7 / 0 → Zlo = 0xFFFFFFFF, Zhi = 7, normal latency.
- `ba_mode`: R0 = 0x55, `ba_mode` = 1, `bus_src` = GPR, `rd_sel` = 0 → `bus_out` = 0; with `ba_mode` = 0 → 0x55. Same-cycle write/read of R5 → old value, then new value.
- Reset mid-MUL at k+10 → `busy` 0, Z = 0, no `done`. Next DIV launches normally.
